seq_config_loader: RTL and testbench

//  Byte-stream controller that configures the 8-channel custom-sequence generator bank.
//  - Receives one 13-byte channel-config frame from the command processor.
//  - Deserialises and validates the frame.
//  - Drives the generator bank's config write interface with a single-cycle update strobe.
//  - Reports completion or error back to the command processor.

---
 rtl/seq_config_loader.sv | 97 +++++++++
 tb/tb_seq_config_loader.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/seq_config_loader.sv
// seq_config_loader: deserialises a 13-byte channel-config frame, validates it and writes the generator bank.
// Optional macro SEQ_CFG_BROADCAST_EN: ch index 0xFF writes identical data to every channel.
module seq_config_loader #(
   parameter int NUM_CHANNELS  = 8,
   parameter int DIVIDER_WIDTH = 16,
   parameter int SEQ_MAX_BITS  = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_start,
   input  logic [7:0]               cmd_data,
   input  logic                     cmd_data_valid,
   output logic                     cmd_data_ready,
   output logic                     cmd_done,
   output logic                     cmd_error,
   output logic                     busy,
   output logic [2:0]               config_ch_index_out,
   output logic [DIVIDER_WIDTH-1:0] config_freq_div_out,
   output logic [SEQ_MAX_BITS-1:0]  config_seq_data_out,
   output logic [6:0]               config_seq_len_out,
   output logic                     config_enable_out,
   output logic                     config_update_strobe
);
   localparam logic [1:0] IDLE = 2'd0, RX = 2'd1, CHECK = 2'd2, APPLY = 2'd3;
   localparam logic [7:0] NCH = 8'(NUM_CHANNELS);
   localparam logic [6:0] SMAX = 7'(SEQ_MAX_BITS);
   logic [1:0] state;
   logic [3:0] cnt;
   logic [7:0] ch;
   logic en;
   logic [DIVIDER_WIDTH-1:0] div;
   logic [6:0] len;
   logic [SEQ_MAX_BITS-1:0] data;
   logic take, bad, last;
   // a byte coinciding with a restart pulse is dropped
   assign take = state == RX && cmd_data_valid && !cmd_start;
`ifdef SEQ_CFG_BROADCAST_EN
   logic bcast;
   assign bad  = (ch >= NCH && ch != 8'hFF) || len == 7'd0 || len > SMAX;
   assign last = !bcast || config_ch_index_out == 3'(NUM_CHANNELS - 1);
`else
   assign bad  = ch >= NCH || len == 7'd0 || len > SMAX;
   assign last = 1'b1;
`endif
   assign cmd_data_ready       = state == RX;
   assign cmd_error            = state == CHECK && bad;
   assign config_update_strobe = state == APPLY;
   assign cmd_done             = state == APPLY && last;
   assign busy                 = state != IDLE;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state               <= IDLE;
         cnt                 <= '0;
         ch                  <= '0;
         en                  <= 1'b0;
         div                 <= '0;
         len                 <= '0;
         data                <= '0;
         config_ch_index_out <= '0;
         config_freq_div_out <= '0;
         config_seq_data_out <= '0;
         config_seq_len_out  <= '0;
         config_enable_out   <= 1'b0;
`ifdef SEQ_CFG_BROADCAST_EN
         bcast               <= 1'b0;
`endif
      end else if (cmd_start && (state == IDLE || state == RX)) begin
         state <= RX;
         cnt   <= '0;
      end else if (take) begin
         cnt <= cnt + 4'd1;
         if (cnt == 4'd12) state <= CHECK;
         if (cnt == 4'd0) ch <= cmd_data;
         if (cnt == 4'd1) en <= cmd_data[0];
         if (cnt == 4'd2) div[15:8] <= cmd_data;
         if (cnt == 4'd3) div[7:0] <= cmd_data;
         if (cnt == 4'd4) len <= cmd_data[6:0];
         if (cnt >= 4'd5) data <= {data[SEQ_MAX_BITS-9:0], cmd_data};
      end else if (state == CHECK) begin
         state <= bad ? IDLE : APPLY;
         if (!bad) begin
`ifdef SEQ_CFG_BROADCAST_EN
            config_ch_index_out <= ch == 8'hFF ? 3'd0 : ch[2:0];
            bcast               <= ch == 8'hFF;
`else
            config_ch_index_out <= ch[2:0];
`endif
            config_freq_div_out <= div;
            config_seq_data_out <= data;
            config_seq_len_out  <= len;
            config_enable_out   <= en;
         end
      end else if (state == APPLY) begin
         state <= last ? IDLE : APPLY;
         if (!last) config_ch_index_out <= config_ch_index_out + 3'd1;
      end
endmodule

// File: tb/tb_seq_config_loader.sv
// tb_seq_config_loader: random and directed frames checked by a queue scoreboard against a frame-level model.
module tb_seq_config_loader;
   typedef logic [7:0] frame_t [13];
   typedef struct {
      bit          err;
      bit          done;
      logic [2:0]  ch;
      logic        en;
      logic [15:0] div;
      logic [6:0]  len;
      logic [63:0] data;
      int          cyc;
   } exp_t;
   logic clk = 0, rst_n = 0, cmd_start = 0, cmd_data_valid = 0;
   logic [7:0] cmd_data = 0;
   logic cmd_data_ready, cmd_done, cmd_error, busy, config_enable_out, config_update_strobe;
   logic [2:0] config_ch_index_out;
   logic [15:0] config_freq_div_out;
   logic [63:0] config_seq_data_out;
   logic [6:0] config_seq_len_out;
   int checks = 0, errors = 0, cyc = 0;
   exp_t sb[$];
   exp_t held = '{default: 0};
   exp_t m;
   seq_config_loader dut (
      .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_data(cmd_data),
      .cmd_data_valid(cmd_data_valid), .cmd_data_ready(cmd_data_ready), .cmd_done(cmd_done),
      .cmd_error(cmd_error), .busy(busy), .config_ch_index_out(config_ch_index_out),
      .config_freq_div_out(config_freq_div_out), .config_seq_data_out(config_seq_data_out),
      .config_seq_len_out(config_seq_len_out), .config_enable_out(config_enable_out),
      .config_update_strobe(config_update_strobe)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", n, a, e, $time);
      end
   endtask
   always @(negedge clk) if (rst_n) begin
      if (config_update_strobe || cmd_error) begin
         if (sb.size() == 0) check("unexpected_event", {config_update_strobe, cmd_error}, 0);
         else begin
            m = sb.pop_front();
            check("cycle", cyc, m.cyc);
            check("error", cmd_error, m.err);
            check("strobe", config_update_strobe, !m.err);
            check("done", cmd_done, m.done);
            check("ch", config_ch_index_out, m.ch);
            check("en", config_enable_out, m.en);
            check("div", config_freq_div_out, m.div);
            check("len", config_seq_len_out, m.len);
            check("data", config_seq_data_out, m.data);
         end
      end else if (cmd_done) check("stray_done", cmd_done, 0);
   end
   function automatic frame_t mk(input logic [7:0] ch, input logic [7:0] en, input logic [15:0] div,
                                 input logic [7:0] len, input logic [63:0] d);
      frame_t f;
      f[0] = ch; f[1] = en; f[2] = div[15:8]; f[3] = div[7:0]; f[4] = len;
      for (int i = 0; i < 8; i++) f[5+i] = d[63-8*i -: 8];
      return f;
   endfunction
   task automatic model(input frame_t b, input int e);
      exp_t x;
      int ch, len, n;
      bit bc;
      ch = b[0];
      len = int'(b[4][6:0]);
      x.en = b[1][0];
      x.div = {b[2], b[3]};
      x.len = b[4][6:0];
      x.data = 0;
      for (int i = 5; i < 13; i++) x.data = (x.data << 8) | 64'(b[i]);
      bc = 0;
`ifdef SEQ_CFG_BROADCAST_EN
      bc = ch == 255;
`endif
      if ((ch >= 8 && !bc) || len < 1 || len > 64) begin
         held.err = 1; held.done = 0; held.cyc = e;
         sb.push_back(held);
         held.err = 0;
      end else begin
         n = bc ? 8 : 1;
         for (int k = 0; k < n; k++) begin
            x.ch = bc ? 3'(k) : 3'(ch);
            x.err = 0;
            x.done = k == n - 1;
            x.cyc = e + 1 + k;
            sb.push_back(x);
            held = x;
         end
      end
   endtask
   task automatic start_pulse(input bit junk);
      cmd_start = 1; cmd_data_valid = junk; cmd_data = 8'hEE;
      @(posedge clk); #1;
      cmd_start = 0; cmd_data_valid = 0;
   endtask
   task automatic send(input logic [7:0] b, input bit gaps);
      while (gaps && $urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
      cmd_data = b; cmd_data_valid = 1;
      @(posedge clk); #1;
      cmd_data_valid = 0;
   endtask
   task automatic run_frame(input frame_t b, input bit gaps, input int pre);
      int w;
      start_pulse(0);
      if (pre > 0) begin
         for (int i = 0; i < pre; i++) send(8'($urandom), gaps);
         start_pulse(1);
      end
      check("busy_rx", busy, 1);
      check("ready_rx", cmd_data_ready, 1);
      for (int i = 0; i < 13; i++) send(b[i], gaps);
      model(b, cyc);
      w = 0;
      while (busy && w < 30) begin @(posedge clk); #1; w++; end
      check("busy_end", busy, 0);
      check("ready_idle", cmd_data_ready, 0);
      check("pending", sb.size(), 0);
      sb.delete();
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog");
      $fatal(1, "timeout");
   end
   initial begin
      frame_t f;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ctrl", {busy, cmd_data_ready, cmd_done, cmd_error, config_update_strobe}, 0);
      check("rst_cfg", {config_ch_index_out, config_freq_div_out, config_seq_len_out, config_enable_out}, 0);
      check("rst_data", config_seq_data_out, 0);
      rst_n = 1;
      @(posedge clk); #1;
      check("ready_idle0", cmd_data_ready, 0);
      run_frame(mk(8'd2, 8'd1, 16'h000A, 8'd8, 64'hA5), 0, 0);
      run_frame(mk(8'd9, 8'd1, 16'h1234, 8'd8, 64'h1), 0, 0);
      run_frame(mk(8'd3, 8'd1, 16'h5555, 8'd0, 64'h2), 0, 0);
      run_frame(mk(8'd3, 8'd1, 16'h5555, 8'd65, 64'h3), 0, 0);
      run_frame(mk(8'd7, 8'hFE, 16'hFFFF, 8'd64, '1), 0, 0);
      run_frame(mk(8'hFF, 8'd1, 16'h0102, 8'd12, 64'hDEAD_BEEF), 0, 0);
      run_frame(mk(8'd1, 8'd3, 16'hBEEF, 8'h90, 64'h0123_4567_89AB_CDEF), 0, 6);
      run_frame(mk(8'd2, 8'd1, 16'h000A, 8'd8, 64'hA5), 1, 0);
      for (int r = 0; r < 40; r++) begin
         for (int i = 0; i < 13; i++) f[i] = 8'($urandom);
         f[0] = $urandom_range(0, 5) == 0 ? 8'($urandom) : 8'($urandom_range(0, 7));
         if ($urandom_range(0, 9) == 0) f[0] = 8'hFF;
         f[4] = $urandom_range(0, 3) == 0 ? 8'($urandom) : {1'($urandom), 7'($urandom_range(1, 64))};
         run_frame(f, 1'($urandom), $urandom_range(0, 3) == 0 ? $urandom_range(1, 12) : 0);
      end
      start_pulse(0);
      for (int i = 0; i < 6; i++) send(8'($urandom), 0);
      #2 rst_n = 0;
      #1;
      check("arst_ctrl", {busy, cmd_data_ready, cmd_done, cmd_error, config_update_strobe}, 0);
      check("arst_cfg", {config_ch_index_out, config_freq_div_out, config_seq_len_out, config_enable_out}, 0);
      check("arst_data", config_seq_data_out, 0);
      held = '{default: 0};
      @(negedge clk);
      rst_n = 1;
      repeat (20) @(posedge clk);
      #1;
      check("post_rst_busy", busy, 0);
      check("post_rst_data", config_seq_data_out, 0);
      run_frame(mk(8'd2, 8'd1, 16'h000A, 8'd8, 64'hA5), 0, 0);
      check("final_pending", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
